// File: rtl/rob_retire.sv
// -----------------------------------------------------------------------------
// rob_retire
//   Retire end of the reorder buffer. Keeps the ROB head/tail pointers, the
//   occupancy count and a per-entry completion bit. Every cycle it retires up
//   to four completed entries in program order, starting at the tail, and
//   returns the retired bundles to the commit logic as registered outputs.
//
//   The parent owns the ROB storage. It reads the entries at o_tail+0..3 and
//   feeds them back combinationally on i_tail_bundle0..3.
//
// Configuration macro:
//   ROB_RETIRE_FLUSH_EN - adds input i_flush. A flush empties the ROB
//                         (head <= tail) and takes priority over dispatch,
//                         writeback and retire in the same cycle.
//
// Parameters:
//   LEN    - number of ROB entries (power of 2, >= 4)
//   BWIDTH - width of one ROB bundle
//   LBITS  - pointer width, $clog2(LEN)
//
// Ports:
//   i_clk               clock
//   i_rst               asynchronous active-high reset
//   i_flush             (ROB_RETIRE_FLUSH_EN only) empty the ROB
//   i_dispatch_count    entries inserted at head this cycle (0..4 legal)
//   i_wb0_valid/_tag    writeback port 0 marks an entry complete
//   i_wb1_valid/_tag    writeback port 1 marks an entry complete
//   i_tail_bundle0..3   ROB contents at o_tail+0..3
//   i_commit_ready      downstream accepts retirement this cycle
//   o_tail              oldest entry index
//   o_head              next insert index
//   o_free              LEN minus occupancy
//   o_empty             occupancy is zero
//   o_retire_valid      thermometer code of retired slots (registered)
//   o_retire_count      number of retired entries (registered)
//   o_retire_bundle0..3 retired bundles, zero above the count (registered)
//   o_error             sticky protocol error (dropped dispatch, stray wb)
// -----------------------------------------------------------------------------
module rob_retire #(
  parameter int LEN    = 16,
  parameter int BWIDTH = 57,
  parameter int LBITS  = $clog2(LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef ROB_RETIRE_FLUSH_EN
  input  logic              i_flush,
`endif
  input  logic [2:0]        i_dispatch_count,
  input  logic              i_wb0_valid,
  input  logic [LBITS-1:0]  i_wb0_tag,
  input  logic              i_wb1_valid,
  input  logic [LBITS-1:0]  i_wb1_tag,
  input  logic [BWIDTH-1:0] i_tail_bundle0,
  input  logic [BWIDTH-1:0] i_tail_bundle1,
  input  logic [BWIDTH-1:0] i_tail_bundle2,
  input  logic [BWIDTH-1:0] i_tail_bundle3,
  input  logic              i_commit_ready,
  output logic [LBITS-1:0]  o_tail,
  output logic [LBITS-1:0]  o_head,
  output logic [LBITS:0]    o_free,
  output logic              o_empty,
  output logic [3:0]        o_retire_valid,
  output logic [2:0]        o_retire_count,
  output logic [BWIDTH-1:0] o_retire_bundle0,
  output logic [BWIDTH-1:0] o_retire_bundle1,
  output logic [BWIDTH-1:0] o_retire_bundle2,
  output logic [BWIDTH-1:0] o_retire_bundle3,
  output logic              o_error
);

  // Wide enough to hold count + 4 without overflow for any LEN >= 4.
  localparam int CW = LBITS + 2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Number of consecutive ones starting at bit 0 (in-order retirement: the
  // first incomplete slot stops everything behind it).
  function automatic logic [2:0] lead_ones(input logic [3:0] c);
    logic [2:0] r;
    casez (c)
      4'b???0: r = 3'd0;
      4'b??01: r = 3'd1;
      4'b?011: r = 3'd2;
      4'b0111: r = 3'd3;
      4'b1111: r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Thermometer code for a retire count of 0..4.
  function automatic logic [3:0] therm(input logic [2:0] n);
    logic [3:0] r;
    case (n)
      3'd0:    r = 4'b0000;
      3'd1:    r = 4'b0001;
      3'd2:    r = 4'b0011;
      3'd3:    r = 4'b0111;
      3'd4:    r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LBITS-1:0]  head_r;
  logic [LBITS-1:0]  tail_r;
  logic [LBITS:0]    count_r;
  logic [LEN-1:0]    done_r;
  logic [3:0]        ret_valid_r;
  logic [2:0]        ret_count_r;
  logic [BWIDTH-1:0] ret_bundle_r [4];
  logic              error_r;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  logic [BWIDTH-1:0] tail_bundle_s [4];
  logic [3:0]        cand_s;
  logic [2:0]        n_s;
  logic [CW-1:0]     count_after_s;
  logic              disp_ok_s;
  logic              disp_err_s;
  logic [2:0]        disp_n_s;
  logic [LBITS-1:0]  wb0_off_s;
  logic [LBITS-1:0]  wb1_off_s;
  logic              wb0_hit_s;
  logic              wb1_hit_s;
  logic              wb0_err_s;
  logic              wb1_err_s;
  logic [LEN-1:0]    done_next_s;
  logic [LBITS:0]    count_next_s;
  logic [LBITS-1:0]  head_next_s;
  logic [LBITS-1:0]  tail_next_s;

  assign tail_bundle_s[0] = i_tail_bundle0;
  assign tail_bundle_s[1] = i_tail_bundle1;
  assign tail_bundle_s[2] = i_tail_bundle2;
  assign tail_bundle_s[3] = i_tail_bundle3;

  // Retire candidates: slot k must be occupied and already complete. Only the
  // registered done bits are used, so a same-cycle writeback waits a cycle.
  always_comb begin
    cand_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cand_s[k] = ((LBITS+1)'(k) < count_r) && done_r[tail_r + LBITS'(k)];
    end
  end

  // Retire count, gated by downstream readiness.
  always_comb begin
    n_s = 3'd0;
    if (i_commit_ready) begin
      n_s = lead_ones(cand_s);
    end else begin
      n_s = 3'd0;
    end
  end

  // Dispatch may reuse slots freed by this cycle's retire. A dispatch that
  // does not fit, or that carries an illegal count, is dropped as a whole.
  assign count_after_s = CW'(count_r) - CW'(n_s) + CW'(i_dispatch_count);
  assign disp_ok_s     = (i_dispatch_count <= 3'd4) && (count_after_s <= CW'(LEN));
  assign disp_err_s    = (i_dispatch_count != 3'd0) && !disp_ok_s;
  assign disp_n_s      = disp_ok_s ? i_dispatch_count : 3'd0;

  // A writeback is legal only for an occupied entry: its distance from the
  // tail (mod LEN) must be below the current occupancy.
  assign wb0_off_s = i_wb0_tag - tail_r;
  assign wb1_off_s = i_wb1_tag - tail_r;
  assign wb0_hit_s = i_wb0_valid && ((LBITS+1)'(wb0_off_s) < count_r);
  assign wb1_hit_s = i_wb1_valid && ((LBITS+1)'(wb1_off_s) < count_r);
  assign wb0_err_s = i_wb0_valid && !wb0_hit_s;
  assign wb1_err_s = i_wb1_valid && !wb1_hit_s;

  // Completion bits: newly dispatched slots are cleared, writebacks set. The
  // two can never target the same index because a dispatch slot is free.
  always_comb begin
    done_next_s = done_r;
    for (int i = 0; i < LEN; i++) begin
      logic [LBITS-1:0] off_v;
      logic             clr_v;
      logic             set_v;
      off_v = LBITS'(i) - head_r;
      clr_v = (LBITS+1)'(off_v) < (LBITS+1)'(disp_n_s);
      set_v = (wb0_hit_s && (i_wb0_tag == LBITS'(i))) ||
              (wb1_hit_s && (i_wb1_tag == LBITS'(i)));
      done_next_s[i] = set_v | (done_r[i] & ~clr_v);
    end
  end

  assign count_next_s = count_r - (LBITS+1)'(n_s) + (LBITS+1)'(disp_n_s);
  assign head_next_s  = head_r + LBITS'(disp_n_s);
  assign tail_next_s  = tail_r + LBITS'(n_s);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Pointer, occupancy, completion, retire output and error state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r      <= {LBITS{1'b0}};
      tail_r      <= {LBITS{1'b0}};
      count_r     <= {(LBITS+1){1'b0}};
      done_r      <= {LEN{1'b0}};
      ret_valid_r <= 4'b0000;
      ret_count_r <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        ret_bundle_r[k] <= {BWIDTH{1'b0}};
      end
      error_r     <= 1'b0;
    end
`ifdef ROB_RETIRE_FLUSH_EN
    else if (i_flush) begin
      // Flush drops everything in flight; the dropped dispatch is not an error.
      head_r      <= tail_r;
      count_r     <= {(LBITS+1){1'b0}};
      done_r      <= {LEN{1'b0}};
      ret_valid_r <= 4'b0000;
      ret_count_r <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        ret_bundle_r[k] <= {BWIDTH{1'b0}};
      end
    end
`endif
    else begin
      head_r      <= head_next_s;
      tail_r      <= tail_next_s;
      count_r     <= count_next_s;
      done_r      <= done_next_s;
      ret_valid_r <= therm(n_s);
      ret_count_r <= n_s;
      for (int k = 0; k < 4; k++) begin
        ret_bundle_r[k] <= (3'(k) < n_s) ? tail_bundle_s[k] : {BWIDTH{1'b0}};
      end
      error_r     <= error_r | disp_err_s | wb0_err_s | wb1_err_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_tail           = tail_r;
  assign o_head           = head_r;
  assign o_free           = (LBITS+1)'(LEN) - count_r;
  assign o_empty          = (count_r == {(LBITS+1){1'b0}});
  assign o_retire_valid   = ret_valid_r;
  assign o_retire_count   = ret_count_r;
  assign o_retire_bundle0 = ret_bundle_r[0];
  assign o_retire_bundle1 = ret_bundle_r[1];
  assign o_retire_bundle2 = ret_bundle_r[2];
  assign o_retire_bundle3 = ret_bundle_r[3];
  assign o_error          = error_r;

endmodule
